// File: rtl/map_port_arbiter.sv
// Round-robin owner of map RAM port B: each grant runs one atomic read-modify-write of a single cell.
// In-range: grant +1 cycle after req, write +RD_LAT+1, done +RD_LAT+2; requests are held off while busy.
module map_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 2,
  parameter int ROWS   = 30,
  parameter int COLS   = 40,
  parameter int CELL_W = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*5-1:0]        req_row,
  input  logic [N_REQ*6-1:0]        req_col,
  input  logic [N_REQ*CELL_W-1:0]   req_obj,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [CELL_W-1:0]         old_obj,
  output logic                      busy,
  output logic [4:0]                ram_addr,
  output logic                      ram_wren,
  output logic [COLS*CELL_W-1:0]    ram_wrdata,
  input  logic [COLS*CELL_W-1:0]    ram_rddata
);

  localparam int WORD_W = COLS * CELL_W;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 6;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam int SH_W   = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last, last_nxt;
  logic [IDX_W-1:0]     win, win_nxt;
  logic [ROW_W-1:0]     row_q, row_nxt;
  logic [COL_W-1:0]     col_q, col_nxt;
  logic [CELL_W-1:0]    obj_q, obj_nxt;
  logic                 err_q, err_q_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [WORD_W-1:0]    rd_word, rd_word_nxt;

  logic [N_REQ-1:0]     grant_nxt, done_nxt, err_nxt;
  logic [CELL_W-1:0]    old_obj_nxt;
  logic                 busy_nxt;
  logic [4:0]           ram_addr_nxt;
  logic                 ram_wren_nxt;
  logic [WORD_W-1:0]    ram_wrdata_nxt;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick;
  logic [ROW_W-1:0]     sel_row;
  logic [COL_W-1:0]     sel_col;
  logic [CELL_W-1:0]    sel_obj;
  logic [N_REQ-1:0]     pick_oh, win_oh;
  logic [SH_W-1:0]      cell_sh;
  logic [WORD_W-1:0]    cell_mask;
  logic [WORD_W-1:0]    wr_word;
  logic [CELL_W-1:0]    old_cell;

  // Circular search starting just after the last winner.
  always_comb begin : arb
    logic [IDX_W-1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % N_REQ);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign sel_row = req_row[ROW_W*pick +: ROW_W];
  assign sel_col = req_col[COL_W*pick +: COL_W];
  assign sel_obj = req_obj[CELL_W*pick +: CELL_W];
  assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
  assign win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win;

  // Column 0 sits in the top nibble, so the shift counts down from the MSB end.
  assign cell_sh   = SH_W'((COLS - 1 - int'(col_q)) * CELL_W);
  assign cell_mask = WORD_W'({CELL_W{1'b1}}) << cell_sh;
  assign wr_word   = (ram_rddata & ~cell_mask) | (WORD_W'(obj_q) << cell_sh);
  assign old_cell  = CELL_W'(rd_word >> cell_sh);

  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    win_nxt        = win;
    row_nxt        = row_q;
    col_nxt        = col_q;
    obj_nxt        = obj_q;
    err_q_nxt      = err_q;
    cnt_nxt        = cnt;
    rd_word_nxt    = rd_word;
    grant_nxt      = '0;
    done_nxt       = '0;
    err_nxt        = '0;
    old_obj_nxt    = '0;
    ram_addr_nxt   = ram_addr;
    ram_wren_nxt   = 1'b0;
    ram_wrdata_nxt = ram_wrdata;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          win_nxt   = pick;
          last_nxt  = pick;
          row_nxt   = sel_row;
          col_nxt   = sel_col;
          obj_nxt   = sel_obj;
          grant_nxt = pick_oh;
          if ((sel_row >= ROW_W'(ROWS)) || (sel_col >= COL_W'(COLS))) begin
            err_q_nxt = 1'b1;
            state_nxt = FIN;
          end else begin
            err_q_nxt    = 1'b0;
            ram_addr_nxt = sel_row;
            cnt_nxt      = CNT_W'(RD_LAT);
            state_nxt    = RD;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          // Merge straight off the read bus so the write lands the cycle after.
          rd_word_nxt    = ram_rddata;
          ram_wren_nxt   = 1'b1;
          ram_wrdata_nxt = wr_word;
          state_nxt      = WR;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR: begin
        done_nxt    = win_oh;
        old_obj_nxt = old_cell;
        state_nxt   = FIN;
      end
      FIN: begin
        // Rejected requests report here, one cycle after their grant.
        if (err_q) begin
          done_nxt = win_oh;
          err_nxt  = win_oh;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= IDX_W'(N_REQ - 1);
      win        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      obj_q      <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
      rd_word    <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      old_obj    <= '0;
      busy       <= 1'b0;
      ram_addr   <= '0;
      ram_wren   <= 1'b0;
      ram_wrdata <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      win        <= win_nxt;
      row_q      <= row_nxt;
      col_q      <= col_nxt;
      obj_q      <= obj_nxt;
      err_q      <= err_q_nxt;
      cnt        <= cnt_nxt;
      rd_word    <= rd_word_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      old_obj    <= old_obj_nxt;
      busy       <= busy_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_wren   <= ram_wren_nxt;
      ram_wrdata <= ram_wrdata_nxt;
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter with a 2-cycle-latency map RAM model on port B.
module tb_map_port_arbiter;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [19:0]   req_row;
  logic [23:0]   req_col;
  logic [15:0]   req_obj;
  logic [3:0]    grant, done, err;
  logic [3:0]    old_obj;
  logic          busy;
  logic [4:0]    ram_addr;
  logic          ram_wren;
  logic [159:0]  ram_wrdata;
  logic [159:0]  ram_rddata;

  always #5 CLOCK_50 = ~CLOCK_50;

  map_port_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req       (req),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_obj   (req_obj),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .old_obj   (old_obj),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wren  (ram_wren),
    .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata)
  );

  // RAM model: read data shows up two cycles after the address.
  bit   [159:0] mem [32];
  bit   [159:0] pipe;
  logic         load_en;
  logic [4:0]   load_addr;
  logic [159:0] load_dat;
  int           cyc = 0;

  always @(posedge CLOCK_50) begin
    cyc        <= cyc + 1;
    pipe       <= mem[ram_addr];
    ram_rddata <= pipe;
    if (load_en) mem[load_addr] <= load_dat;
    else if (ram_wren) mem[ram_addr] <= ram_wrdata;
  end

  typedef struct {
    int           kind;   // 0 grant, 1 write, 2 done
    int           who;
    int           lat;
    logic [4:0]   addr;
    logic [159:0] data;
    logic [3:0]   old;
    logic         is_err;
  } ev_t;

  ev_t          q[$];
  bit   [159:0] shd [32];
  int           errors = 0;
  int           checks = 0;
  int           req_cyc = 0;
  bit           rearm = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] cell_get(input logic [159:0] w, input int c);
    return w[159-4*c -: 4];
  endfunction

  function automatic logic [159:0] cell_put(input logic [159:0] w, input int c, input logic [3:0] v);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < 40; k++) r[159-4*k -: 4] = (k == c) ? v : w[159-4*k -: 4];
    return r;
  endfunction

  task automatic set_pl(input int i, input int row, input int col, input int obj);
    req_row[5*i +: 5] = 5'(row);
    req_col[6*i +: 6] = 6'(col);
    req_obj[4*i +: 4] = 4'(obj);
  endtask

  task automatic expect_op(input int who, input int row, input int col, input int obj, input int lat);
    ev_t e;
    logic [159:0] nw;
    e = '{kind: 0, who: who, lat: lat, addr: 5'd0, data: 160'd0, old: 4'd0, is_err: 1'b0};
    q.push_back(e);
    if (row >= 30 || col >= 40) begin
      e.kind = 2; e.is_err = 1'b1; e.old = 4'd0;
      q.push_back(e);
    end else begin
      nw = cell_put(shd[row], col, 4'(obj));
      e.kind = 1; e.addr = 5'(row); e.data = nw;
      q.push_back(e);
      e.kind = 2; e.old = cell_get(shd[row], col);
      q.push_back(e);
      shd[row] = nw;
    end
  endtask

  task automatic pop(output ev_t e, output bit ok);
    e  = '{kind: -1, who: 0, lat: -1, addr: 5'd0, data: 160'd0, old: 4'd0, is_err: 1'b0};
    ok = (q.size() != 0);
    if (ok) e = q.pop_front();
    else check("unexpected_event", 160'(1), 160'(0));
  endtask

  // Monitor: every DUT output event pops the next expected event.
  initial begin : monitor
    ev_t        e;
    bit         ok;
    int         g_cyc;
    logic [3:0] oh;
    g_cyc = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset === 1'b1) begin
        if (|grant) begin
          pop(e, ok);
          if (ok) begin
            oh = 4'b0001 << e.who;
            check("grant_order", 160'(e.kind), 160'(0));
            check("grant_vec", 160'(grant), 160'(oh));
            if (e.lat >= 0) check("grant_lat", 160'(cyc - req_cyc), 160'(e.lat));
          end
          g_cyc = cyc;
        end
        if (ram_wren) begin
          pop(e, ok);
          if (ok) begin
            check("write_order", 160'(e.kind), 160'(1));
            check("write_addr", 160'(ram_addr), 160'(e.addr));
            check("write_data", ram_wrdata, e.data);
            check("write_lat", 160'(cyc - g_cyc), 160'(3));
          end
        end
        if (|done) begin
          pop(e, ok);
          if (ok) begin
            oh = 4'b0001 << e.who;
            check("done_order", 160'(e.kind), 160'(2));
            check("done_vec", 160'(done), 160'(oh));
            check("done_err", 160'(err), 160'(e.is_err ? oh : 4'b0000));
            check("done_old", 160'(old_obj), 160'(e.old));
            check("done_lat", 160'(cyc - g_cyc), 160'(e.is_err ? 1 : 4));
          end
        end
      end
    end
  end

  // Requester behaviour: drop req on its grant; optionally re-raise req[0] once after done[0].
  task automatic run(input int n, input int budget);
    int got;
    int t;
    got = 0;
    t   = 0;
    while (got < n && t < budget) begin
      @(negedge CLOCK_50);
      t++;
      req = req & ~grant;
      if (|done) begin
        got++;
        if (rearm && done[0]) begin
          req[0] = 1'b1;
          rearm  = 1'b0;
        end
      end
    end
    if (got < n) check("timeout_done", 160'(got), 160'(n));
    @(negedge CLOCK_50);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 160'(grant), 160'(0));
    check({tag, "_done"}, 160'(done), 160'(0));
    check({tag, "_err"}, 160'(err), 160'(0));
    check({tag, "_old"}, 160'(old_obj), 160'(0));
    check({tag, "_busy"}, 160'(busy), 160'(0));
    check({tag, "_addr"}, 160'(ram_addr), 160'(0));
    check({tag, "_wren"}, 160'(ram_wren), 160'(0));
    check({tag, "_wrdata"}, ram_wrdata, 160'(0));
  endtask

  initial begin : stim
    logic [159:0] lit;
    int           t;
    reset = 1'b0; req = '0; req_row = '0; req_col = '0; req_obj = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0;
    repeat (3) @(negedge CLOCK_50);
    check_quiet("reset");

    load_en = 1'b1; load_addr = 5'd3; load_dat = 160'h0123456789ABCDEF0123456789ABCDEF01234567;
    shd[3] = 160'h0123456789ABCDEF0123456789ABCDEF01234567;
    @(negedge CLOCK_50);
    load_en = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);

    // Basic RMW of row 3, col 5 (old nibble 5)
    set_pl(0, 3, 5, 'hA);
    expect_op(0, 3, 5, 'hA, 1);
    req = 4'b0001; req_cyc = cyc;
    run(1, 50);
    check("basic_ram_row3", mem[3], 160'h01234A6789ABCDEF0123456789ABCDEF01234567);
    check("basic_busy_after", 160'(busy), 160'(0));

    // Out of range: col 40, then row 30
    set_pl(2, 0, 40, 7);
    expect_op(2, 0, 40, 7, 1);
    req = 4'b0100; req_cyc = cyc;
    run(1, 50);
    set_pl(1, 30, 0, 7);
    expect_op(1, 30, 0, 7, 1);
    req = 4'b0010; req_cyc = cyc;
    run(1, 50);
    check("oor_ram_row0", mem[0], 160'(0));

    // Round robin from last=1: order 2,3,0,1
    for (int i = 0; i < 4; i++) set_pl(i, 10 + i, 5 * i + 3, i + 1);
    expect_op(2, 12, 13, 3, 1);
    expect_op(3, 13, 18, 4, -1);
    expect_op(0, 10, 3, 1, -1);
    expect_op(1, 11, 8, 2, -1);
    req = 4'b1111; req_cyc = cyc;
    run(4, 200);

    // Boundary cells on zero row 7
    set_pl(3, 7, 0, 'hF);
    expect_op(3, 7, 0, 'hF, 1);
    req = 4'b1000; req_cyc = cyc;
    run(1, 50);
    lit = 160'hF;
    lit = lit << 156;
    check("boundary_col0", mem[7], lit);
    set_pl(3, 7, 39, 'hF);
    expect_op(3, 7, 39, 'hF, 1);
    req = 4'b1000; req_cyc = cyc;
    run(1, 50);
    lit = lit | 160'hF;
    check("boundary_col39", mem[7], lit);

    // Round robin from last=3: order 0,1,2,3
    for (int i = 0; i < 4; i++) set_pl(i, 14 + i, 39 - i, 15 - i);
    expect_op(0, 14, 39, 15, 1);
    expect_op(1, 15, 38, 14, -1);
    expect_op(2, 16, 37, 13, -1);
    expect_op(3, 17, 36, 12, -1);
    req = 4'b1111; req_cyc = cyc;
    run(4, 200);

    // Starvation: req[0] comes back right after its done, req[3] still wins op 2
    set_pl(0, 20, 1, 1);
    set_pl(3, 21, 2, 2);
    expect_op(0, 20, 1, 1, 1);
    expect_op(3, 21, 2, 2, -1);
    expect_op(0, 20, 1, 1, -1);
    rearm = 1'b1;
    req = 4'b1001; req_cyc = cyc;
    run(3, 300);

    // Reset during RD
    set_pl(2, 4, 1, 9);
    q.push_back('{kind: 0, who: 2, lat: 1, addr: 5'd0, data: 160'd0, old: 4'd0, is_err: 1'b0});
    req = 4'b0100; req_cyc = cyc;
    t = 0;
    do begin
      @(negedge CLOCK_50);
      t++;
    end while (grant == 4'b0000 && t < 20);
    if (grant == 4'b0000) check("timeout_grant", 160'(0), 160'(1));
    req = req & ~grant;
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (3) @(negedge CLOCK_50);
    check("midreset_wren", 160'(ram_wren), 160'(0));
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("midreset_ram_row4", mem[4], 160'(0));

    for (int i = 0; i < 4; i++) set_pl(i, 22 + i, 10 + i, 5 + i);
    expect_op(0, 22, 10, 5, 1);
    expect_op(1, 23, 11, 6, -1);
    expect_op(2, 24, 12, 7, -1);
    expect_op(3, 25, 13, 8, -1);
    req = 4'b1111; req_cyc = cyc;
    run(4, 200);

    repeat (5) @(negedge CLOCK_50);
    check("scoreboard_drained", 160'(q.size()), 160'(0));
    check("final_busy", 160'(busy), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
